// File: rtl/merge_sort_pkg.sv
// Shared types and helpers for the merge_sort_stream block.
package merge_sort_pkg;

  localparam int DEF_COLUMN      = 3;
  localparam int DEF_ELEMENT_LEN = 8;

  // One row at the default geometry; byte c lives at bits [c*8 +: 8].
  typedef logic [DEF_COLUMN*DEF_ELEMENT_LEN-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    MERGE = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Width of a selector over n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/merge_sort_stream_row_compare.sv
// Cyclic lexicographic row compare: bytes key_sel, key_sel+1, ... mod COLUMN.
// take_a is high when row a must go first; equal rows take a (stable merge).
module row_compare import merge_sort_pkg::*; #(
  parameter int COLUMN      = 3,
  parameter int ELEMENT_LEN = 8,
  parameter int KW          = clog2_min1(COLUMN)
) (
  input  logic [COLUMN*ELEMENT_LEN-1:0] a,
  input  logic [COLUMN*ELEMENT_LEN-1:0] b,
  input  logic [KW-1:0]                 key_sel,
  input  logic                          descending,
  output logic                          take_a
);

  int                     start;
  int                     idx;
  logic                   decided;
  logic [ELEMENT_LEN-1:0] byte_a;
  logic [ELEMENT_LEN-1:0] byte_b;

  // First differing byte in rotation order decides; ties fall through to take a.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    start   = (int'(key_sel) >= COLUMN) ? 0 : int'(key_sel);
    idx     = 0;
    decided = 1'b0;
    byte_a  = '0;
    byte_b  = '0;
    take_a  = 1'b1;
    for (int i = 0; i < COLUMN; i++) begin
      idx = start + i;
      if (idx >= COLUMN) idx = idx - COLUMN;
      byte_a = a[idx*ELEMENT_LEN +: ELEMENT_LEN];
      byte_b = b[idx*ELEMENT_LEN +: ELEMENT_LEN];
      if (!decided && (byte_a != byte_b)) begin
        decided = 1'b1;
        take_a  = descending ? (byte_a > byte_b) : (byte_a < byte_b);
      end
    end
  end

endmodule

// File: rtl/merge_sort_stream.sv
// Iterative bottom-up merge sorter: LOAD rows into bank 0, run log2(ROWS)
// merge passes ping-ponging between two banks (one row written per cycle),
// then DRAIN the final bank over a registered valid/ready output.
// Optional feature macro: SORT_INDEX_EN adds an arrival-order tag per row and
// an out_index port carrying it alongside out_data.
module merge_sort_stream import merge_sort_pkg::*; #(
  parameter int ROWS        = 32,
  parameter int COLUMN      = 3,
  parameter int ELEMENT_LEN = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [COLUMN*ELEMENT_LEN-1:0]   in_data,
  input  logic [clog2_min1(COLUMN)-1:0]   key_sel,
  input  logic                            descending,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [COLUMN*ELEMENT_LEN-1:0]   out_data,
  output logic                            out_last,
  output logic                            busy,
  output logic                            sorted
`ifdef SORT_INDEX_EN
  , output logic [$clog2(ROWS)-1:0]       out_index
`endif
);

  localparam int RW = COLUMN*ELEMENT_LEN;
  localparam int AW = $clog2(ROWS);
  localparam int KW = clog2_min1(COLUMN);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_LOAD  = LOAD;
  localparam logic [1:0] ST_MERGE = MERGE;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  localparam logic [AW-1:0] ONE_A  = AW'(1);
  localparam logic [AW-1:0] HALF_A = AW'(ROWS/2);
  localparam logic [AW-1:0] LAST_A = AW'(ROWS-1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_q;          // next load address
  logic [AW-1:0] cnt_q;         // merge destination address within the pass
  logic [AW-1:0] w_q;           // current run width
  logic [AW-1:0] lcnt_q;        // rows already taken from the left run
  logic          src_q;         // bank being read during MERGE / DRAIN
  logic [AW:0]   rd_q;          // drain read address; top bit = all rows issued
  logic [KW-1:0] key_q;
  logic          desc_q;
  logic          out_valid_q, out_last_q, sorted_q;
  logic [RW-1:0] out_data_q;
  logic [RW-1:0] bank_q [2][ROWS];

  logic [AW-1:0] mask, off, base, rcnt, l_addr, r_addr, load_addr;
  logic          l_exh, r_exh, take_a, take_left, pair_end, pass_end, last_pass;
  logic          load_fire, drain_load, accept_last;
  logic [RW-1:0] row_l, row_r, mrow;

  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign sorted    = sorted_q;

  assign load_fire   = in_valid && in_ready;
  assign load_addr   = (state_q == ST_IDLE) ? '0 : wr_q;
  assign drain_load  = (state_q == ST_DRAIN) && !rd_q[AW] && (!out_valid_q || out_ready);
  assign accept_last = out_valid_q && out_ready && out_last_q;

  // Run-pair bookkeeping: the right count is implied by position minus left count.
  always_comb begin
    mask      = AW'((w_q << 1) - ONE_A);   // 2*width-1; wraps to all-ones on the last pass
    off       = cnt_q & mask;
    base      = cnt_q & ~mask;
    rcnt      = off - lcnt_q;
    l_addr    = base + lcnt_q;
    r_addr    = base + w_q + rcnt;
    l_exh     = (lcnt_q == w_q);
    r_exh     = (rcnt == w_q);
    pair_end  = (off == mask);
    pass_end  = (cnt_q == LAST_A);
    last_pass = (w_q == HALF_A);
    row_l     = bank_q[src_q][l_addr];
    row_r     = bank_q[src_q][r_addr];
    take_left = !l_exh && (r_exh || take_a);
    mrow      = take_left ? row_l : row_r;
  end

  row_compare #(
    .COLUMN      (COLUMN),
    .ELEMENT_LEN (ELEMENT_LEN),
    .KW          (KW)
  ) u_cmp (
    .a          (row_l),
    .b          (row_r),
    .key_sel    (key_q),
    .descending (desc_q),
    .take_a     (take_a)
  );

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = ST_LOAD;
      ST_LOAD:  if (in_valid && (wr_q == LAST_A)) state_d = ST_MERGE;
      ST_MERGE: if (pass_end && last_pass) state_d = ST_DRAIN;
      ST_DRAIN: if (accept_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control registers: load counter, merge pointers, pass/bank swap, drain address.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      wr_q    <= '0;
      cnt_q   <= '0;
      w_q     <= ONE_A;
      lcnt_q  <= '0;
      src_q   <= 1'b0;
      rd_q    <= '0;
      key_q   <= '0;
      desc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (in_valid) begin
          wr_q   <= ONE_A;
          key_q  <= key_sel;
          desc_q <= descending;
        end
        ST_LOAD: if (in_valid) begin
          wr_q <= wr_q + ONE_A;
          if (wr_q == LAST_A) begin
            cnt_q  <= '0;
            w_q    <= ONE_A;
            lcnt_q <= '0;
            src_q  <= 1'b0;
          end
        end
        ST_MERGE: begin
          cnt_q  <= cnt_q + ONE_A;
          lcnt_q <= pair_end ? '0 : lcnt_q + AW'(take_left);
          if (pass_end) begin
            src_q <= ~src_q;
            w_q   <= w_q << 1;
            rd_q  <= '0;
          end
        end
        ST_DRAIN: if (drain_load) rd_q <= rd_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Registered output stage; holds row and last flag while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      sorted_q    <= 1'b0;
    end else begin
      sorted_q <= 1'b0;
      if (drain_load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bank_q[src_q][rd_q[AW-1:0]];
        out_last_q  <= (rd_q[AW-1:0] == LAST_A);
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        sorted_q    <= out_last_q;
      end
    end
  end

  // Row storage: input rows go to bank 0, merge results to the non-source bank.
  always_ff @(posedge clk) begin
    // NOTE: bank storage is left unreset; every entry is written before it is read.
    if (load_fire) bank_q[0][load_addr] <= in_data;
    else if (state_q == ST_MERGE) bank_q[~src_q][cnt_q] <= mrow;
  end

`ifdef SORT_INDEX_EN
  logic [AW-1:0] tag_q [2][ROWS];
  logic [AW-1:0] out_index_q;

  assign out_index = out_index_q;

  // Arrival-order tags follow their rows through every merge pass.
  always_ff @(posedge clk) begin
    if (load_fire) tag_q[0][load_addr] <= load_addr;
    else if (state_q == ST_MERGE)
      tag_q[~src_q][cnt_q] <= take_left ? tag_q[src_q][l_addr] : tag_q[src_q][r_addr];
  end

  // Tag output register, updated in step with out_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_index_q <= '0;
    else if (drain_load) out_index_q <= tag_q[src_q][rd_q[AW-1:0]];
  end
`endif

endmodule
